retire_commit_unit: RTL and testbench

Retire-side consumer of the ROB's two retire packets. It commits each retired result to the committed physical register file and returns each packet's superseded physical register (old_rd) to rename's free list through a buffered valid/ready stream. It also throttles the ROB with a registered stall when the return buffer cannot absorb another two-wide retire.

---
 rtl/retire_commit_unit_pkg.sv | 30 +++
 rtl/retire_commit_unit_fifo.sv | 81 ++++++++
 rtl/retire_commit_unit.sv | 118 +++++++++++
 tb/tb_retire_commit_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/retire_commit_unit_pkg.sv
// rtl/retire_commit_unit_pkg.sv - retire packet layout and shared constants
//
// Purpose: retire packet field layout, preg width default and PREG_ZERO.
// Packet layout, MSB first: {valid, rd, old_rd, data}.
// Ports: none (package).
package retire_commit_unit_pkg;

  localparam int RCU_PREG_W      = 6;
  localparam int RCU_DATA_W      = 32;
  localparam int RETIRE_DATA_LSB  = 0;
  localparam int RETIRE_OLDRD_LSB = RCU_DATA_W;
  localparam int RETIRE_RD_LSB    = RCU_DATA_W + RCU_PREG_W;
  localparam int RETIRE_VALID_BIT = RCU_DATA_W + 2 * RCU_PREG_W;
  localparam int RETIRE_WIDTH     = RETIRE_VALID_BIT + 1;

  // p0 is the architectural zero register and is never returned to the free list
  localparam logic [RCU_PREG_W-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [RCU_PREG_W-1:0] rd;
    logic [RCU_PREG_W-1:0] old_rd;
    logic [RCU_DATA_W-1:0] data;
  } retire_pkt_t;

  function automatic retire_pkt_t unpack_retire(input logic [RETIRE_WIDTH-1:0] raw);
    return retire_pkt_t'(raw);
  endfunction

endpackage

// File: rtl/retire_commit_unit_fifo.sv
// rtl/retire_commit_unit_fifo.sv - 2-push/1-pop free-list return FIFO
//
// Module freelist_return_fifo.
// Purpose: buffers freed pregs; up to two pushes (slot 0 before slot 1) and
// one pop per cycle. A same-cycle pop frees a slot for a push. Pushes that do
// not fit are dropped (slot 1 first) and set a sticky overflow flag.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   push0_valid_i/data_i     older push request
//   push1_valid_i/data_i     younger push request
//   pop_i                    remove head (only asserted when count_o != 0)
//   head_o                   head entry
//   count_o                  current occupancy
//   free_space_o             free slots after this cycle's pushes/pop
//   ovf_o                    sticky overflow
module freelist_return_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0_valid_i,
  input  logic [W-1:0]             push0_data_i,
  input  logic                     push1_valid_i,
  input  logic [W-1:0]             push1_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_space_o,
  output logic                     ovf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, wptr_p1;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] space, n_push;
  logic          ovf_q, ovf_d;
  logic          acc0, acc1;
  logic [W-1:0]  first_data;

  always_comb begin
    space      = CW'(DEPTH) - count_q + CW'(pop_i);
    acc0       = push0_valid_i && (space != '0);
    // slot 1 needs a second free slot only when slot 0 is also pushing
    acc1       = push1_valid_i && (push0_valid_i ? (space >= CW'(2)) : (space != '0));
    first_data = acc0 ? push0_data_i : push1_data_i;
    n_push     = CW'(acc0) + CW'(acc1);
    ovf_d      = ovf_q | (push0_valid_i & ~acc0) | (push1_valid_i & ~acc1);
    count_d    = count_q + n_push - CW'(pop_i);
    wptr_p1    = wptr_q + PW'(1);
    wptr_d     = wptr_q + n_push[PW-1:0];
    rptr_d     = rptr_q + PW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (acc0 || acc1) mem_q[wptr_q] <= first_data;
      if (acc0 && acc1) mem_q[wptr_p1] <= push1_data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign head_o       = mem_q[rptr_q];
  assign count_o      = count_q;
  assign free_space_o = CW'(DEPTH) - count_d;
  assign ovf_o        = ovf_q;

endmodule

// File: rtl/retire_commit_unit.sv
// rtl/retire_commit_unit.sv - commits retired results and returns old pregs
//
// Purpose: registers committed-PRF writes for two retire packets, pushes each
// non-zero old_rd into the free-list return FIFO, and raises a registered
// stall when fewer than two FIFO slots remain.
// Config macro: COMMIT_COUNT_EN enables the retired-instruction counter;
// otherwise commit_count is tied to 0.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   retire0, retire1            older/younger retire packets
//   retire_stall                to ROB: retire nothing next cycle
//   prf_we*/waddr*/wdata*       committed-PRF write ports
//   free_valid/free_preg/free_ready  freed-preg stream to rename
//   ovf_err                     sticky return-FIFO overflow
//   commit_count                retired-instruction count
module retire_commit_unit
  import retire_commit_unit_pkg::*;
#(
  parameter int FREE_DEPTH = 8,
  parameter int PREG_W     = RCU_PREG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RETIRE_WIDTH-1:0] retire0,
  input  logic [RETIRE_WIDTH-1:0] retire1,
  output logic                    retire_stall,
  output logic                    prf_we0,
  output logic                    prf_we1,
  output logic [PREG_W-1:0]       prf_waddr0,
  output logic [PREG_W-1:0]       prf_waddr1,
  output logic [31:0]             prf_wdata0,
  output logic [31:0]             prf_wdata1,
  output logic                    free_valid,
  output logic [PREG_W-1:0]       free_preg,
  input  logic                    free_ready,
  output logic                    ovf_err,
  output logic [31:0]             commit_count
);

  localparam int CW = $clog2(FREE_DEPTH) + 1;

  retire_pkt_t p0, p1;
  logic [CW-1:0] fifo_count, fifo_space;
  logic          push0, push1, pop;

  logic              we0_q, we1_q, stall_q;
  logic [PREG_W-1:0] waddr0_q, waddr1_q;
  logic [31:0]       wdata0_q, wdata1_q;

  assign p0    = unpack_retire(retire0);
  assign p1    = unpack_retire(retire1);
  assign push0 = p0.valid && (p0.old_rd != PREG_ZERO);
  assign push1 = p1.valid && (p1.old_rd != PREG_ZERO);
  assign pop   = free_valid && free_ready;

  freelist_return_fifo #(
    .DEPTH (FREE_DEPTH),
    .W     (PREG_W)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push0_valid_i (push0),
    .push0_data_i  (p0.old_rd),
    .push1_valid_i (push1),
    .push1_data_i  (p1.old_rd),
    .pop_i         (pop),
    .head_o        (free_preg),
    .count_o       (fifo_count),
    .free_space_o  (fifo_space),
    .ovf_o         (ovf_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      we0_q   <= p0.valid;
      we1_q   <= p1.valid;
      if (p0.valid) begin
        waddr0_q <= p0.rd;
        wdata0_q <= p0.data;
      end
      if (p1.valid) begin
        waddr1_q <= p1.rd;
        wdata1_q <= p1.data;
      end
      // stall once a further two-wide retire could not be absorbed
      stall_q <= (fifo_space < CW'(2));
    end
  end

  assign prf_we0      = we0_q;
  assign prf_we1      = we1_q;
  assign prf_waddr0   = waddr0_q;
  assign prf_waddr1   = waddr1_q;
  assign prf_wdata0   = wdata0_q;
  assign prf_wdata1   = wdata1_q;
  assign retire_stall = stall_q;
  assign free_valid   = (fifo_count != '0);

`ifdef COMMIT_COUNT_EN
  logic [31:0] commit_count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) commit_count_q <= '0;
    else      commit_count_q <= commit_count_q + 32'(p0.valid) + 32'(p1.valid);
  end
  assign commit_count = commit_count_q;
`else
  assign commit_count = '0;
`endif

endmodule

// File: tb/tb_retire_commit_unit.sv
// tb/tb_retire_commit_unit.sv - self-checking bench for retire_commit_unit
module tb_retire_commit_unit;
  import retire_commit_unit_pkg::*;

  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [RETIRE_WIDTH-1:0] retire0 = '0;
  logic [RETIRE_WIDTH-1:0] retire1 = '0;
  logic                    retire_stall;
  logic                    prf_we0, prf_we1;
  logic [5:0]              prf_waddr0, prf_waddr1;
  logic [31:0]             prf_wdata0, prf_wdata1;
  logic                    free_valid;
  logic [5:0]              free_preg;
  logic                    free_ready = 1'b0;
  logic                    ovf_err;
  logic [31:0]             commit_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [5:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic        m_stall = 1'b0;
  logic        m_we0 = 1'b0, m_we1 = 1'b0;
  logic [5:0]  m_wa0 = '0, m_wa1 = '0;
  logic [31:0] m_wd0 = '0, m_wd1 = '0;
  logic [31:0] m_cnt = '0;

  retire_commit_unit #(.FREE_DEPTH(DEPTH), .PREG_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .retire0      (retire0),
    .retire1      (retire1),
    .retire_stall (retire_stall),
    .prf_we0      (prf_we0),
    .prf_we1      (prf_we1),
    .prf_waddr0   (prf_waddr0),
    .prf_waddr1   (prf_waddr1),
    .prf_wdata0   (prf_wdata0),
    .prf_wdata1   (prf_wdata1),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .free_ready   (free_ready),
    .ovf_err      (ovf_err),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 32'(retire_stall), 0);
    check_eq({tag, "_we0"}, 32'(prf_we0), 0);
    check_eq({tag, "_we1"}, 32'(prf_we1), 0);
    check_eq({tag, "_wa0"}, 32'(prf_waddr0), 0);
    check_eq({tag, "_wa1"}, 32'(prf_waddr1), 0);
    check_eq({tag, "_wd0"}, prf_wdata0, 0);
    check_eq({tag, "_wd1"}, prf_wdata1, 0);
    check_eq({tag, "_fvalid"}, 32'(free_valid), 0);
    check_eq({tag, "_fpreg"}, 32'(free_preg), 0);
    check_eq({tag, "_ovf"}, 32'(ovf_err), 0);
    check_eq({tag, "_cnt"}, commit_count, 0);
  endtask

  // Reset held for n edges while valid retires are offered; all outputs stay 0.
  task automatic do_reset(input int n);
    rst = 1'b0;
    retire0 = {1'b1, 6'd11, 6'd4, 32'hDEAD_0001};
    retire1 = {1'b1, 6'd12, 6'd6, 32'hDEAD_0002};
    free_ready = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (n) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    retire0 = '0;
    retire1 = '0;
    rst = 1'b1;
    m_q.delete();
    m_ovf = 0; m_stall = 0; m_we0 = 0; m_we1 = 0;
    m_wa0 = 0; m_wa1 = 0; m_wd0 = 0; m_wd1 = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    check_eq("post_rst_fvalid", 32'(free_valid), 0);
    check_eq("post_rst_stall", 32'(retire_stall), 0);
  endtask

  // One clock: drive the packets, advance the model, check every output.
  task automatic step(input logic v0, input logic [5:0] rd0, input logic [5:0] old0,
                      input logic [31:0] d0, input logic v1, input logic [5:0] rd1,
                      input logic [5:0] old1, input logic [31:0] d1, input logic rdy);
    int space;
    retire0    = {v0, rd0, old0, d0};
    retire1    = {v1, rd1, old1, d1};
    free_ready = rdy;
    space = DEPTH - m_q.size();
    if (m_q.size() != 0 && rdy) begin
      void'(m_q.pop_front());
      space++;
    end
    if (v0 && old0 != 0) begin
      if (space > 0) begin m_q.push_back(old0); space--; end
      else m_ovf = 1'b1;
    end
    if (v1 && old1 != 0) begin
      if (space > 0) begin m_q.push_back(old1); space--; end
      else m_ovf = 1'b1;
    end
    m_we0 = v0;
    m_we1 = v1;
    if (v0) begin m_wa0 = rd0; m_wd0 = d0; end
    if (v1) begin m_wa1 = rd1; m_wd1 = d1; end
    m_stall = (DEPTH - m_q.size()) < 2;
`ifdef COMMIT_COUNT_EN
    m_cnt = m_cnt + 32'(v0) + 32'(v1);
`endif
    @(posedge clk);
    #1;
    check_eq("we0", 32'(prf_we0), 32'(m_we0));
    check_eq("we1", 32'(prf_we1), 32'(m_we1));
    if (m_we0) begin
      check_eq("waddr0", 32'(prf_waddr0), 32'(m_wa0));
      check_eq("wdata0", prf_wdata0, m_wd0);
    end
    if (m_we1) begin
      check_eq("waddr1", 32'(prf_waddr1), 32'(m_wa1));
      check_eq("wdata1", prf_wdata1, m_wd1);
    end
    check_eq("stall", 32'(retire_stall), 32'(m_stall));
    check_eq("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check_eq("free_valid", 32'(free_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("free_preg", 32'(free_preg), 32'(m_q[0]));
    check_eq("commit_count", commit_count, m_cnt);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    do_reset(3);

    // dual retire, then head advances 3 -> 5
    step(1, 6'd12, 6'd3, 32'h1111_0012, 1, 6'd13, 6'd5, 32'h2222_0013, 1);
    check_eq("dual_head", 32'(free_preg), 3);
    idle(1);
    check_eq("dual_head2", 32'(free_preg), 5);
    idle(1);

    // old_rd 0 on retire0 is never freed
    step(1, 6'd20, 6'd0, 32'hA0A0_0020, 1, 6'd21, 6'd7, 32'hB0B0_0021, 1);
    check_eq("p0_skip_head", 32'(free_preg), 7);
    idle(1);
    idle(1);

    // fill to 6, then 8, then overflow
    for (int i = 0; i < 3; i++)
      step(1, 6'(30 + i), 6'(2 * i + 1), 32'(i), 1, 6'(40 + i), 6'(2 * i + 2), 32'(i + 100), 0);
    step(1, 6'd50, 6'd60, 32'h50, 1, 6'd51, 6'd61, 32'h51, 0);
    check_eq("full_no_ovf", 32'(ovf_err), 0);
    check_eq("full_stall", 32'(retire_stall), 1);
    step(1, 6'd52, 6'd9, 32'h52, 0, 0, 0, 0, 0);
    check_eq("ovf_set", 32'(ovf_err), 1);

    // full FIFO, push + pop in one cycle, then drain to see wrap order
    step(1, 6'd53, 6'd10, 32'h53, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) idle(1);

    // reset mid-operation with queued entries
    step(1, 6'd1, 6'd33, 32'h1, 1, 6'd2, 6'd34, 32'h2, 0);
    do_reset(2);

    // randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      logic v0, v1, rdy;
      logic [5:0] o0, o1;
      v0  = ($urandom % 4) != 0;
      v1  = ($urandom % 3) != 0;
      o0  = (($urandom % 5) == 0) ? 6'd0 : 6'($urandom);
      o1  = (($urandom % 5) == 0) ? 6'd0 : 6'($urandom);
      rdy = (i < 300) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
      step(v0, 6'($urandom), o0, $urandom, v1, 6'($urandom), o1, $urandom, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
